// File: rtl/symbol_upsampler_pkg.sv
// Shared types and constants for the PAM-4 symbol upsampler front end.
// Holds the sample width, Gray-coded symbol values, FSM states and the level mapper.
package symbol_upsampler_pkg;

  localparam int DATA_W = 32;
  localparam int PH_W   = 4;

  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_P3 = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // Gray code to signed level: adjacent levels differ by one bit.
  function automatic logic signed [DATA_W-1:0] map_symbol(input logic [1:0] sym,
                                                          input int amp);
    logic signed [DATA_W-1:0] a1;
    logic signed [DATA_W-1:0] a3;
    logic signed [DATA_W-1:0] lvl;
    a1 = DATA_W'(amp);
    a3 = (a1 <<< 1) + a1;
    case (sym)
      SYM_M3:  lvl = -a3;
      SYM_M1:  lvl = -a1;
      SYM_P1:  lvl = a1;
      SYM_P3:  lvl = a3;
      default: lvl = '0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/symbol_upsampler_sym_fifo.sv
// Small synchronous FIFO buffering incoming symbols ahead of the upsampler FSM.
// Push when full and pop when empty are ignored; reset flushes the pointers and count.
module sym_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/symbol_upsampler.sv
// PAM-4 symbol upsampler: maps buffered symbols to signed levels and zero-stuffs
// SPS-1 samples per symbol to drive the pulse-shaping FIR input.
module symbol_upsampler
  import symbol_upsampler_pkg::*;
#(
  parameter int SPS        = 4,
  parameter int AMP        = 8192,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              sym_valid_i,
  input  logic [1:0]        sym_data_i,
  output logic              sym_ready_o,
  output logic [DATA_W-1:0] xout_o,
  output logic [DATA_W-1:0] yout_o,
  output logic              sym_strobe_o,
  output logic              underrun_o,
  input  logic              clr_underrun_i
);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d, phase_inc;
  logic [DATA_W-1:0] xout_q, xout_d;
  logic              strobe_q, strobe_d;
  logic              underrun_q, underrun_d;
  logic              underrun_set;

  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_head;

  assign sym_ready_o = rst_ni && !fifo_full;
  assign fifo_push   = sym_valid_i && sym_ready_o;

  sym_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (sym_data_i),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign phase_inc = (phase_q == PH_W'(SPS - 1)) ? '0 : phase_q + PH_W'(1);

  // A started symbol period always runs to completion; en is only looked at on phase 0.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    xout_d       = '0;
    strobe_d     = 1'b0;
    underrun_set = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i && !fifo_empty) begin
          xout_d   = map_symbol(fifo_head, AMP);
          fifo_pop = 1'b1;
          strobe_d = 1'b1;
          phase_d  = phase_inc;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (phase_q != '0) begin
          phase_d = phase_inc;
        end else if (!en_i) begin
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_inc;
          if (!fifo_empty) begin
            xout_d   = map_symbol(fifo_head, AMP);
            fifo_pop = 1'b1;
            strobe_d = 1'b1;
          end else begin
            underrun_set = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign underrun_d = underrun_set ? 1'b1 : (clr_underrun_i ? 1'b0 : underrun_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      xout_q     <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      xout_q     <= xout_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign xout_o       = xout_q;
  assign yout_o       = '0;
  assign sym_strobe_o = strobe_q;
  assign underrun_o   = underrun_q;

endmodule
